// File: rtl/identify_pkg.sv
// Shared POWER ISA opcode constants, field types and slice helpers for the identify stage.
// Optional perf counter in the top is enabled with IDENTIFY_PERF_CNT_EN.
package identify_pkg;

  typedef logic [0:31] word_t;

  typedef struct packed {
    logic iForm;
    logic bForm;
    logic condLr;
    logic condCtr;
    logic condTar;
  } bru_forms_t;

  localparam logic [5:0] PO_PREFIX = 6'd1;
  localparam logic [5:0] PO_BC     = 6'd16;
  localparam logic [5:0] PO_B      = 6'd18;
  localparam logic [5:0] PO_XL     = 6'd19;

  localparam logic [9:0] XO_BCLR   = 10'd16;
  localparam logic [9:0] XO_BCCTR  = 10'd528;
  localparam logic [9:0] XO_BCTAR  = 10'd560;

  // Big-endian numbering: bit 0 is the MSB of the word.
  function automatic logic [5:0] getPo(input word_t w);
    return w[0:5];
  endfunction

  function automatic logic [9:0] getXo(input word_t w);
    return w[21:30];
  endfunction

endpackage

// File: rtl/identify_if.sv
// Bus between the fetch side (master) and the identify stage (slave).
import identify_pkg::*;

interface identify_if;
  logic        i_en;
  logic [0:63] i_instr;
  word_t       o_bru_instr;
  logic        o_bru_en;
  logic        o_bru_i_form;
  logic        o_bru_b_form;
  logic        o_bru_cond_LR;
  logic        o_bru_cond_CTR;
  logic        o_bru_cond_TAR;

  modport master (
    output i_en, i_instr,
    input  o_bru_instr, o_bru_en, o_bru_i_form, o_bru_b_form,
           o_bru_cond_LR, o_bru_cond_CTR, o_bru_cond_TAR
  );

  modport slave (
    input  i_en, i_instr,
    output o_bru_instr, o_bru_en, o_bru_i_form, o_bru_b_form,
           o_bru_cond_LR, o_bru_cond_CTR, o_bru_cond_TAR
  );
endinterface

// File: rtl/identify_bru_decode.sv
// Pure combinational branch-form decode of a single 32-bit instruction word.
import identify_pkg::*;

module identify_bru_decode (
  input  word_t      instr_i,
  output bru_forms_t forms_o
);

  logic [5:0] po;
  logic [9:0] xo;

  assign po = getPo(instr_i);
  assign xo = getXo(instr_i);

  // Opcode 19 is shared with mcrf, isync and the CR logicals, so only three XOs count.
  always_comb begin
    forms_o = '0;
    case (po)
      PO_B:  forms_o.iForm = 1'b1;
      PO_BC: forms_o.bForm = 1'b1;
      PO_XL: begin
        case (xo)
          XO_BCLR:  forms_o.condLr  = 1'b1;
          XO_BCCTR: forms_o.condCtr = 1'b1;
          XO_BCTAR: forms_o.condTar = 1'b1;
          default:  forms_o = '0;
        endcase
      end
      default: forms_o = '0;
    endcase
  end

endmodule

// File: rtl/identify.sv
// Identify stage top: gates the branch decode with enable/reset and forwards branches to the BRU.
// Define IDENTIFY_PERF_CNT_EN to add the o_branch_cnt branch counter.
import identify_pkg::*;

module identify (
  input  logic       i_clk,
  input  logic       i_rst,
  identify_if.slave  bus
`ifdef IDENTIFY_PERF_CNT_EN
  ,
  output logic [31:0] o_branch_cnt
`endif
);

  word_t      firstWord;
  bru_forms_t rawForms;
  bru_forms_t forms;
  logic       active;
  logic       bruEn;

  assign firstWord = bus.i_instr[0:31];
  assign active    = bus.i_en & ~i_rst;

  identify_bru_decode uDecode (
    .instr_i (firstWord),
    .forms_o (rawForms)
  );

  assign forms = active ? rawForms : '0;
  assign bruEn = |forms;

  assign bus.o_bru_en       = bruEn;
  assign bus.o_bru_i_form   = forms.iForm;
  assign bus.o_bru_b_form   = forms.bForm;
  assign bus.o_bru_cond_LR  = forms.condLr;
  assign bus.o_bru_cond_CTR = forms.condCtr;
  assign bus.o_bru_cond_TAR = forms.condTar;
  assign bus.o_bru_instr    = bruEn ? firstWord : '0;

`ifdef IDENTIFY_PERF_CNT_EN
  logic [31:0] branchCnt_q;
  logic [31:0] branchCnt_d;
  logic [31:0] unusedBits;

  // Reset wins over increment; the add wraps naturally at 32 bits.
  always_comb begin
    branchCnt_d = branchCnt_q;
    if (i_rst)
      branchCnt_d = '0;
    else if (bruEn)
      branchCnt_d = branchCnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    branchCnt_q <= branchCnt_d;
  end

  assign o_branch_cnt = branchCnt_q;
  assign unusedBits   = bus.i_instr[32:63];
`else
  logic [32:0] unusedBits;

  assign unusedBits = {i_clk, bus.i_instr[32:63]};
`endif

endmodule

// File: tb/tb_identify.sv
// Directed self-checking bench for the identify stage, including the optional counter build.
import identify_pkg::*;

module tb_identify;

  logic clk;
  logic rst;
  int   totalCount;
  int   badCount;

  identify_if bus ();

`ifdef IDENTIFY_PERF_CNT_EN
  logic [31:0] branchCnt;
`endif

  identify dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
`ifdef IDENTIFY_PERF_CNT_EN
    ,
    .o_branch_cnt (branchCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flags packed as {bru_en, i_form, b_form, cond_LR, cond_CTR, cond_TAR}.
  typedef struct {
    logic [31:0] word;
    logic [31:0] suffix;
    logic [5:0]  flags;
    string       name;
  } vec_t;

  function automatic logic [5:0] observedFlags();
    return {bus.o_bru_en, bus.o_bru_i_form, bus.o_bru_b_form,
            bus.o_bru_cond_LR, bus.o_bru_cond_CTR, bus.o_bru_cond_TAR};
  endfunction

  task automatic applyStimulus(input logic en, input logic r, input logic [31:0] w, input logic [31:0] s);
    bus.i_en    = en;
    rst         = r;
    bus.i_instr = {w, s};
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 32'h48032BFB, 32'h0);
    totalCount++;
    if (observedFlags() !== 6'b000000) begin
      badCount++;
      $display("[TB] FAIL reset_flags got=%b want=%b", observedFlags(), 6'b000000);
    end
    totalCount++;
    if (bus.o_bru_instr !== 32'h0) begin
      badCount++;
      $display("[TB] FAIL reset_instr got=%h want=%h", bus.o_bru_instr, 32'h0);
    end
`ifdef IDENTIFY_PERF_CNT_EN
    @(posedge clk);
    @(negedge clk);
    totalCount++;
    if (branchCnt !== 32'd0) begin
      badCount++;
      $display("[TB] FAIL reset_cnt got=%0d want=%0d", branchCnt, 0);
    end
`endif
  endtask

  task automatic test_branch_forms();
    vec_t vecs[6];
    vecs[0] = '{32'h48032BFB, 32'hDEADBEEF, 6'b110000, "b_iform"};
    vecs[1] = '{32'h4182000C, 32'h00000000, 6'b101000, "bc_bform"};
    vecs[2] = '{32'h4E800020, 32'h00000000, 6'b100100, "blr"};
    vecs[3] = '{32'h4E800021, 32'hFFFFFFFF, 6'b100100, "blrl"};
    vecs[4] = '{32'h4E800420, 32'h00000000, 6'b100010, "bctr"};
    vecs[5] = '{32'h4E800460, 32'h12345678, 6'b100001, "bctar"};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].word, vecs[i].suffix);
      totalCount++;
      if (observedFlags() !== vecs[i].flags) begin
        badCount++;
        $display("[TB] FAIL %s_flags got=%b want=%b", vecs[i].name, observedFlags(), vecs[i].flags);
      end
      totalCount++;
      if (bus.o_bru_instr !== vecs[i].word) begin
        badCount++;
        $display("[TB] FAIL %s_instr got=%h want=%h", vecs[i].name, bus.o_bru_instr, vecs[i].word);
      end
    end
  endtask

  task automatic test_non_branch();
    vec_t vecs[6];
    vecs[0] = '{32'h38600001, 32'h00000000, 6'b000000, "addi"};
    vecs[1] = '{32'h4C00012C, 32'h00000000, 6'b000000, "isync"};
    vecs[2] = '{32'h04000000, 32'h48000000, 6'b000000, "prefix"};
    vecs[3] = '{32'h38600001, 32'h4E800020, 6'b000000, "suffix_ignored"};
    vecs[4] = '{32'h4C000000, 32'h00000000, 6'b000000, "mcrf"};
    vecs[5] = '{32'h4E800022, 32'h00000000, 6'b000000, "xl_xo17"};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].word, vecs[i].suffix);
      totalCount++;
      if (observedFlags() !== vecs[i].flags) begin
        badCount++;
        $display("[TB] FAIL %s_flags got=%b want=%b", vecs[i].name, observedFlags(), vecs[i].flags);
      end
      totalCount++;
      if (bus.o_bru_instr !== 32'h0) begin
        badCount++;
        $display("[TB] FAIL %s_instr got=%h want=%h", vecs[i].name, bus.o_bru_instr, 32'h0);
      end
    end
  endtask

  task automatic test_gating();
    logic [1:0] ctl[3];
    ctl[0] = 2'b00;
    ctl[1] = 2'b11;
    ctl[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ctl[i][1], ctl[i][0], 32'h4E800420, 32'h0);
      totalCount++;
      if (observedFlags() !== 6'b000000) begin
        badCount++;
        $display("[TB] FAIL gate%0d_flags got=%b want=%b", i, observedFlags(), 6'b000000);
      end
      totalCount++;
      if (bus.o_bru_instr !== 32'h0) begin
        badCount++;
        $display("[TB] FAIL gate%0d_instr got=%h want=%h", i, bus.o_bru_instr, 32'h0);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h4E800420, 32'h0);
    totalCount++;
    if (observedFlags() !== 6'b100010) begin
      badCount++;
      $display("[TB] FAIL gate_release got=%b want=%b", observedFlags(), 6'b100010);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 32'h48000000, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h40000000, 32'h0);
    totalCount++;
    if (observedFlags() !== 6'b101000) begin
      badCount++;
      $display("[TB] FAIL b2b_bform got=%b want=%b", observedFlags(), 6'b101000);
    end
    applyStimulus(1'b1, 1'b0, 32'h7C000000, 32'h0);
    totalCount++;
    if (bus.o_bru_en !== 1'b0 || bus.o_bru_instr !== 32'h0) begin
      badCount++;
      $display("[TB] FAIL b2b_drop got=%b/%h want=0/00000000", bus.o_bru_en, bus.o_bru_instr);
    end
  endtask

`ifdef IDENTIFY_PERF_CNT_EN
  task automatic test_counter();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h48000000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h48000000, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h38600001, 32'h0);
    @(posedge clk);
    @(negedge clk);
    totalCount++;
    if (branchCnt !== 32'd3) begin
      badCount++;
      $display("[TB] FAIL cnt_three got=%0d want=%0d", branchCnt, 3);
    end
    applyStimulus(1'b1, 1'b1, 32'h48000000, 32'h0);
    @(posedge clk);
    @(negedge clk);
    totalCount++;
    if (branchCnt !== 32'd0) begin
      badCount++;
      $display("[TB] FAIL cnt_clear got=%0d want=%0d", branchCnt, 0);
    end
    applyStimulus(1'b1, 1'b0, 32'h4E800020, 32'h0);
    @(posedge clk);
    @(negedge clk);
    totalCount++;
    if (branchCnt !== 32'd1) begin
      badCount++;
      $display("[TB] FAIL cnt_restart got=%0d want=%0d", branchCnt, 1);
    end
  endtask
`endif

  initial begin
    totalCount  = 0;
    badCount    = 0;
    rst         = 1'b1;
    bus.i_en    = 1'b0;
    bus.i_instr = '0;
    #2;
    test_reset();
    test_branch_forms();
    test_non_branch();
    test_gating();
    test_back_to_back();
`ifdef IDENTIFY_PERF_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
